// File: rtl/gpsreceiver2_capture.sv
// gpsreceiver2_capture: packs front-end IF samples into a RAM capture buffer with Wishbone readout/control
module gpsreceiver2_capture #(
    parameter int SAMPLE_W   = 2,
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic [31:0]         wb_adr_i,
    output logic [31:0]         wb_dat_o,
    input  logic [31:0]         wb_dat_i,
    input  logic [3:0]          wb_sel_i,
    input  logic                wb_stb_i,
    input  logic                wb_cyc_i,
    output logic                wb_ack_o,
    input  logic                wb_we_i,
    input  logic [SAMPLE_W-1:0] smp_dat,
    input  logic                smp_stb,
    output logic                irq
);
    localparam int PER_WORD = 32 / SAMPLE_W;
    localparam int IDX_W    = (PER_WORD > 1) ? $clog2(PER_WORD) : 1;

    typedef enum logic {IDLE, CAPTURE} state_t;

    state_t                state_q, state_d;
    logic [DEPTH_LOG2-1:0] ptr, end_ptr;
    logic [IDX_W-1:0]      idx;
    logic [31:0]           shreg, word_d, csr_rd, ram_rd;
    logic [DEPTH_LOG2:0]   length;
    logic                  circ, irq_en, done, wrapped;
    logic                  req, csr_wr, csr_sel, busy, last, cap_stb, word_wr, fin;
    logic                  arm, stop, st_clr;
    logic [1:0]            reg_i;
    logic [31:0]           mem [2**DEPTH_LOG2];
    logic                  unused;

    // sel_i is ignored and only part of the address/data buses is decoded
    assign unused  = ^{wb_sel_i, wb_adr_i, wb_dat_i};

    assign req     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign csr_sel = wb_adr_i[DEPTH_LOG2+2];
    assign reg_i   = wb_adr_i[3:2];
    assign csr_wr  = req & wb_we_i & csr_sel;
    assign arm     = csr_wr & (reg_i == 2'd0) & wb_dat_i[0];
    assign stop    = csr_wr & (reg_i == 2'd0) & wb_dat_i[2] & ~arm;
    assign st_clr  = csr_wr & (reg_i == 2'd1) & wb_dat_i[1];
    assign busy    = (state_q == CAPTURE);
    assign last    = (idx == IDX_W'(PER_WORD - 1));
    assign cap_stb = busy & smp_stb & ~arm & ~stop;
    assign word_wr = cap_stb & last;
    assign end_ptr = (length == '0 || length[DEPTH_LOG2]) ? '1 : length[DEPTH_LOG2-1:0] - DEPTH_LOG2'(1);
    assign fin     = (word_wr & ~circ & (ptr == end_ptr)) | (busy & stop);
    assign irq     = done & irq_en;
    assign ram_rd  = mem[wb_adr_i[DEPTH_LOG2+1:2]];
    assign csr_rd  = (reg_i == 2'd0) ? {28'd0, irq_en, 1'b0, circ, 1'b0} :
                     (reg_i == 2'd1) ? {29'd0, wrapped, done, busy} :
                     (reg_i == 2'd2) ? 32'(ptr) : 32'(length);

    // merge the incoming sample into the partial word at its slot
    always_comb begin
        word_d = shreg;
        word_d[int'(idx) * SAMPLE_W +: SAMPLE_W] = smp_dat;
    end

    // next state: ARM (re)starts, STOP or one-shot end returns to idle
    always_comb begin
        state_d = state_q;
        if (arm)
            state_d = CAPTURE;
        else if (busy && fin)
            state_d = IDLE;
    end

    // state register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // write pointer and sample packer
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ptr   <= '0;
            idx   <= '0;
            shreg <= '0;
        end else if (arm) begin
            ptr <= '0;
            idx <= '0;
        end else if (cap_stb) begin
            shreg <= word_d;
            idx   <= last ? '0 : idx + IDX_W'(1);
            ptr   <= last ? ptr + DEPTH_LOG2'(1) : ptr;
        end
    end

    // capture RAM write port, contents survive reset
    always_ff @(posedge sys_clk) begin
        if (word_wr)
            mem[ptr] <= word_d;
    end

    // control and status registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            circ    <= 1'b0;
            irq_en  <= 1'b0;
            length  <= '0;
            done    <= 1'b0;
            wrapped <= 1'b0;
        end else begin
            if (csr_wr && reg_i == 2'd0) begin
                circ   <= wb_dat_i[1];
                irq_en <= wb_dat_i[3];
            end
            if (csr_wr && reg_i == 2'd3)
                length <= wb_dat_i[DEPTH_LOG2:0];
            done    <= arm ? 1'b0 : fin ? 1'b1 : st_clr ? 1'b0 : done;
            wrapped <= arm ? 1'b0 : (word_wr && circ && ptr == '1) ? 1'b1 : wrapped;
        end
    end

    // single-wait-state Wishbone ack and registered read data
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= req;
            if (req && !wb_we_i)
                wb_dat_o <= csr_sel ? csr_rd : {ram_rd[7:0], ram_rd[15:8], ram_rd[23:16], ram_rd[31:24]};
        end
    end
endmodule

// File: tb/tb_gpsreceiver2_capture.sv
// tb_gpsreceiver2_capture: directed self-checking bench for the capture buffer
module tb_gpsreceiver2_capture;
    logic        clk = 0;
    logic        rst_n = 0;
    logic [31:0] a_adr = 0, a_wdat = 0, a_rdat, b_adr = 0, b_wdat = 0, b_rdat;
    logic        a_we = 0, a_stb = 0, a_cyc = 0, a_ack, a_ss = 0, a_irq;
    logic        b_we = 0, b_stb = 0, b_cyc = 0, b_ack, b_ss = 0, b_irq;
    logic [1:0]  a_sd = 0;
    logic [7:0]  b_sd = 0;
    int          tests = 0, fails = 0;
    logic [31:0] rdata;
    int          lat;

    always #5 clk = ~clk;

    gpsreceiver2_capture #(.SAMPLE_W(2), .DEPTH_LOG2(9)) dut_a (
        .sys_clk(clk), .sys_rst_n(rst_n), .wb_adr_i(a_adr), .wb_dat_o(a_rdat), .wb_dat_i(a_wdat),
        .wb_sel_i(4'hF), .wb_stb_i(a_stb), .wb_cyc_i(a_cyc), .wb_ack_o(a_ack), .wb_we_i(a_we),
        .smp_dat(a_sd), .smp_stb(a_ss), .irq(a_irq));

    gpsreceiver2_capture #(.SAMPLE_W(8), .DEPTH_LOG2(2)) dut_b (
        .sys_clk(clk), .sys_rst_n(rst_n), .wb_adr_i(b_adr), .wb_dat_o(b_rdat), .wb_dat_i(b_wdat),
        .wb_sel_i(4'hF), .wb_stb_i(b_stb), .wb_cyc_i(b_cyc), .wb_ack_o(b_ack), .wb_we_i(b_we),
        .smp_dat(b_sd), .smp_stb(b_ss), .irq(b_irq));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wb(input bit u, input bit we, input logic [31:0] adr, input logic [31:0] dat);
        @(negedge clk);
        if (u) begin b_cyc = 1; b_stb = 1; b_we = we; b_adr = adr; b_wdat = dat; end
        else   begin a_cyc = 1; a_stb = 1; a_we = we; a_adr = adr; a_wdat = dat; end
        lat = 0;
        rdata = 32'hDEADDEAD;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (u ? b_ack : a_ack) begin
                lat = i;
                rdata = u ? b_rdat : a_rdat;
                break;
            end
        end
        if (u) begin b_cyc = 0; b_stb = 0; b_we = 0; end
        else   begin a_cyc = 0; a_stb = 0; a_we = 0; end
        check("ack_latency", lat, 1);
        @(negedge clk);
        check("ack_single", {31'd0, u ? b_ack : a_ack}, 0);
    endtask

    task automatic rd(input bit u, input logic [31:0] adr, input logic [31:0] exp, input string tag);
        wb(u, 0, adr, 0);
        check(tag, rdata, exp);
    endtask

    task automatic smp(input bit u, input logic [7:0] v);
        @(negedge clk);
        if (u) begin b_ss = 1; b_sd = v; end else begin a_ss = 1; a_sd = v[1:0]; end
        @(negedge clk);
        b_ss = 0;
        a_ss = 0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1;
        check("rst_ack", {31'd0, a_ack}, 0);
        check("rst_dat", a_rdat, 0);
        check("rst_irq", {31'd0, a_irq}, 0);
        rd(0, 32'h800, 0, "rst_ctrl");
        rd(0, 32'h804, 0, "rst_status");
        rd(0, 32'h808, 0, "rst_wrptr");
        rd(0, 32'h80C, 0, "rst_length");

        wb(0, 1, 32'h80C, 2);
        wb(0, 1, 32'h800, 1);
        rd(0, 32'h800, 0, "t1_ctrl_arm_reads0");
        rd(0, 32'h804, 1, "t1_busy");
        for (int i = 0; i < 32; i++) smp(0, 8'(i % 4));
        rd(0, 32'h804, 2, "t1_done");
        rd(0, 32'h808, 2, "t1_wrptr");
        rd(0, 32'h000, 32'hE4E4E4E4, "t1_word0");
        rd(0, 32'h004, 32'hE4E4E4E4, "t1_word1");
        for (int i = 0; i < 8; i++) smp(0, 8'd3);
        rd(0, 32'h808, 2, "t1_ignored_after_done");
        rd(0, 32'h80C, 2, "t1_length");

        wb(1, 1, 32'h1C, 1);
        wb(1, 1, 32'h10, 1);
        smp(1, 8'h11); smp(1, 8'h22); smp(1, 8'h33); smp(1, 8'h44);
        rd(1, 32'h00, 32'h11223344, "t2_swap");
        rd(1, 32'h14, 2, "t2_done");
        rd(1, 32'h18, 1, "t2_wrptr");

        wb(1, 1, 32'h1C, 0);
        wb(1, 1, 32'h10, 3);
        for (int w = 0; w < 6; w++)
            for (int s = 0; s < 4; s++) smp(1, 8'(w + 1));
        rd(1, 32'h14, 5, "t3_wrapped_busy");
        rd(1, 32'h18, 2, "t3_wrptr");
        rd(1, 32'h00, 32'h05050505, "t3_word0");
        rd(1, 32'h04, 32'h06060606, "t3_word1");
        rd(1, 32'h08, 32'h03030303, "t3_word2");
        wb(1, 1, 32'h10, 6);
        rd(1, 32'h14, 6, "t3_stop_done");
        rd(1, 32'h18, 2, "t3_stop_wrptr");
        rd(1, 32'h10, 2, "t3_ctrl_circ");

        wb(0, 1, 32'h80C, 1);
        wb(0, 1, 32'h800, 9);
        for (int i = 0; i < 16; i++) smp(0, 8'd3);
        check("t4_irq_set", {31'd0, a_irq}, 1);
        rd(0, 32'h804, 2, "t4_done");
        rd(0, 32'h800, 8, "t4_ctrl_irqen");
        rd(0, 32'h000, 32'hFFFFFFFF, "t4_word0");
        wb(0, 1, 32'h804, 2);
        check("t4_irq_clr", {31'd0, a_irq}, 0);
        rd(0, 32'h804, 0, "t4_done_clr");

        wb(0, 1, 32'h80C, 0);
        wb(0, 1, 32'h800, 1);
        for (int i = 0; i < 8; i++) smp(0, 8'd1);
        wb(0, 1, 32'h800, 1);
        for (int i = 0; i < 16; i++) smp(0, 8'(3 - (i % 4)));
        rd(0, 32'h808, 1, "t5_rearm_wrptr");
        rd(0, 32'h000, 32'h1B1B1B1B, "t5_rearm_word0");
        for (int i = 0; i < 8; i++) smp(0, 8'd2);
        wb(0, 1, 32'h800, 4);
        rd(0, 32'h808, 1, "t5_stop_wrptr");
        rd(0, 32'h804, 2, "t5_stop_done");
        check("t5_irq_off", {31'd0, a_irq}, 0);

        wb(0, 1, 32'h800, 9);
        for (int i = 0; i < 16; i++) smp(0, 8'd2);
        for (int i = 0; i < 5; i++) smp(0, 8'd1);
        rd(0, 32'h804, 1, "t6_busy");
        @(negedge clk);
        rst_n = 0;
        #1;
        check("t6_rst_dat", a_rdat, 0);
        check("t6_rst_ack", {31'd0, a_ack}, 0);
        check("t6_rst_irq", {31'd0, a_irq}, 0);
        @(negedge clk);
        rst_n = 1;
        rd(0, 32'h800, 0, "t6_ctrl");
        rd(0, 32'h804, 0, "t6_status");
        rd(0, 32'h808, 0, "t6_wrptr");
        rd(0, 32'h80C, 0, "t6_length");
        rd(0, 32'h000, 32'hAAAAAAAA, "t6_ram_kept");
        for (int i = 0; i < 16; i++) smp(0, 8'd3);
        rd(0, 32'h808, 0, "t6_idle_ignores");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
